prog_memory: RTL and testbench
==============================

# prog_memory

Parametrised, field-loadable instruction memory for the single-cycle board processor. It replaces the fixed 8-word instruction store, holding 2**ADDR_W words of DATA_W bits with a registered read port and an external (switch) override path. It adds a load FSM that writes a new program word-by-word from the board switches without re-synthesis. The block sits between the program counter / control FSM (read side) and the debounced switch/button front end (load side).

## Interface
- DATA_W, 12, instruction word width in bits
- ADDR_W, 3, address width; depth DEPTH = 2**ADDR_W
- FILL, all ones, reset value of every word not covered by the boot image
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- rd_en  in  1  read request for rd_addr
- rd_addr  in  ADDR_W  read address
- ext_sel  in  1  1 = return ext_data instead of memory contents
- ext_data  in  DATA_W  externally supplied instruction (switches)
- rd_data  out  DATA_W  registered read data
- rd_valid  out  1  rd_data updated this cycle
- ld_start  in  1  single-cycle pulse: begin program load at word 0
- ld_we  in  1  single-cycle pulse: write ld_data at load pointer
- ld_data  in  DATA_W  word to load
- ld_busy  out  1  load in progress
- ld_done  out  1  one-cycle pulse after final word written
- ld_ptr  out  ADDR_W  next word to be written

## Operation
- Reset: memory = boot image (see Configuration), rd_data = 0, rd_valid = 0, ld_busy = 0, ld_done = 0, ld_ptr = 0, FSM = IDLE.
- Read path (IDLE only): on rd_en, rd_data <= ext_sel ? ext_data : mem[rd_addr]; rd_valid <= 1. Without rd_en, rd_data holds and rd_valid <= 0.
- FSM states: IDLE, LOAD, DONE.
- IDLE -> LOAD on ld_start: ld_ptr <= 0, ld_busy <= 1. An ld_we in IDLE is ignored; memory unchanged.
- In LOAD, each ld_we: mem[ld_ptr] <= ld_data, ld_ptr <= ld_ptr + 1.
  - Write at ld_ptr = DEPTH-1: ld_ptr wraps to 0, FSM -> DONE.
- DONE: ld_done = 1 for exactly one cycle, ld_busy = 0; FSM -> IDLE next cycle.
- ld_start during LOAD restarts: ld_ptr <= 0, no write that cycle even if ld_we = 1; words already written keep their new values.
- ld_start in DONE is ignored.
- Reads during LOAD or DONE: rd_en ignored, rd_data holds, rd_valid = 0. The control FSM must stall while ld_busy = 1.
- ext_sel is sampled only with rd_en; it never affects memory contents.
- Reset mid-load: memory returns to the boot image, partial load discarded.

## Timing
- Read latency: 1 cycle (rd_en at edge N -> rd_data/rd_valid valid after edge N+1).
- Write: word visible to a read issued at least one cycle after the writing edge.
- A full load of DEPTH words takes DEPTH ld_we pulses. ld_done rises the cycle after the last write. The first read is accepted the cycle after ld_done.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- PROG_MEM_BOOTIMG_EN defined, DATA_W = 12, ADDR_W >= 3: reset image is
  - words 0..7 = 0x012, 0x214, 0x4C1, 0x681, 0x904, 0xB04, 0xC07, 0xFFF (load, store, sub, add, ascending sort, descending sort, display, dummy);
  - words above 7 = FILL.
- Macro not defined, or any other width: every word resets to FILL.

## Test plan
- Reset with PROG_MEM_BOOTIMG_EN, then rd_en at addr 0..7 -> rd_data 0x012, 0x214, 0x4C1, 0x681, 0x904, 0xB04, 0xC07, 0xFFF, each 1 cycle after its request with rd_valid = 1.
- ext_sel = 1, ext_data = 0xABC, rd_en at addr 3 -> rd_data = 0xABC. Then ext_sel = 0 -> 0x681 (memory unchanged).
- ld_start, then 8 ld_we with data 0x100+i -> ld_done pulses once, ld_ptr = 0. Reads of addr i return 0x100+i.
- ld_we in IDLE with 0x555 -> no write; addr 0 still reads 0x012. rd_en during LOAD -> rd_valid stays 0, rd_data holds.
- Write 3 words, ld_start, write 8 words 0x200+i -> memory = 0x200+i, single ld_done at the end.
- rst after 4 load writes -> ld_busy = 0, ld_ptr = 0, addr 0..3 read the boot image again. Without the macro, all reads return 0xFFF.

Source files
------------

// File: rtl/prog_memory.sv
// ---------------------------------------------------------------------------
// prog_memory
//
// Field-loadable instruction memory for the single-cycle board processor.
// Holds 2**ADDR_W words of DATA_W bits with a registered read port and an
// external (switch) override. A small load FSM (IDLE / LOAD / DONE) writes a
// new program word by word from the board switches without re-synthesis.
//
// Optional feature macro: PROG_MEM_BOOTIMG_EN
//   defined     -> with DATA_W = 12 and ADDR_W >= 3, words 0..7 reset to the
//                  demo boot program; every other word resets to FILL
//   not defined -> every word resets to FILL
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous, active-high reset
//   rd_en     in   read request for rd_addr (honoured in IDLE only)
//   rd_addr   in   read address
//   ext_sel   in   1 = return ext_data instead of memory contents
//   ext_data  in   externally supplied instruction word
//   rd_data   out  registered read data
//   rd_valid  out  rd_data updated this cycle
//   ld_start  in   pulse: begin (or restart) a program load at word 0
//   ld_we     in   pulse: write ld_data at the load pointer
//   ld_data   in   word to load
//   ld_busy   out  load in progress
//   ld_done   out  one-cycle pulse after the final word is written
//   ld_ptr    out  next word to be written
// ---------------------------------------------------------------------------
module prog_memory #(
  parameter int                DATA_W = 12,
  parameter int                ADDR_W = 3,
  parameter logic [DATA_W-1:0] FILL   = '1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              ext_sel,
  input  logic [DATA_W-1:0] ext_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              ld_start,
  input  logic              ld_we,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_busy,
  output logic              ld_done,
  output logic [ADDR_W-1:0] ld_ptr
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ld_ptr_q, ld_ptr_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  // Reset value of word idx. The boot program only makes sense for the
  // original 12-bit instruction set, so other widths fall back to FILL.
  function automatic logic [DATA_W-1:0] boot_word(input int idx);
    logic [DATA_W-1:0] w;
    w = FILL;
`ifdef PROG_MEM_BOOTIMG_EN
    if (DATA_W == 12 && ADDR_W >= 3) begin
      case (idx)
        0:       w = DATA_W'(12'h012);
        1:       w = DATA_W'(12'h214);
        2:       w = DATA_W'(12'h4C1);
        3:       w = DATA_W'(12'h681);
        4:       w = DATA_W'(12'h904);
        5:       w = DATA_W'(12'hB04);
        6:       w = DATA_W'(12'hC07);
        7:       w = DATA_W'(12'hFFF);
        default: w = FILL;
      endcase
    end
`endif
    return w;
  endfunction

  // State, pointer, read port and memory registers. Reset restores the boot
  // image, which also discards any partially loaded program.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ld_ptr_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= boot_word(i);
      end
    end else begin
      state_q    <= state_d;
      ld_ptr_q   <= ld_ptr_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Load FSM next state and memory writes. A restart (ld_start in LOAD)
  // takes priority over ld_we, so that cycle never writes.
  always_comb begin
    state_d  = state_q;
    ld_ptr_d = ld_ptr_q;
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    case (state_q)
      IDLE: begin
        if (ld_start) begin
          state_d  = LOAD;
          ld_ptr_d = '0;
        end
      end
      LOAD: begin
        if (ld_start) begin
          ld_ptr_d = '0;
        end else if (ld_we) begin
          mem_d[ld_ptr_q] = ld_data;
          if (ld_ptr_q == ADDR_W'(DEPTH - 1)) begin
            ld_ptr_d = '0;
            state_d  = DONE;
          end else begin
            ld_ptr_d = ld_ptr_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Read port: only IDLE accepts requests; otherwise the data holds and
  // rd_valid drops so the control FSM sees no fresh instruction.
  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    if (state_q == IDLE && rd_en) begin
      rd_data_d  = ext_sel ? ext_data : mem_q[rd_addr];
      rd_valid_d = 1'b1;
    end
  end

  // Outputs are pure decodes of registers.
  always_comb begin
    rd_data  = rd_data_q;
    rd_valid = rd_valid_q;
    ld_ptr   = ld_ptr_q;
    ld_busy  = (state_q == LOAD);
    ld_done  = (state_q == DONE);
  end

endmodule

// File: tb/tb_prog_memory.sv
// ---------------------------------------------------------------------------
// tb_prog_memory
//
// Self-checking bench for prog_memory with default parameters (12-bit words,
// 8 entries). Directed vectors and hand-written load sequences are followed
// by randomized traffic; every cycle is compared against a behavioural model
// of the memory, the loader and the read port.
// ---------------------------------------------------------------------------
module tb_prog_memory;

  localparam int DATA_W = 12;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 8;

  logic              clk;
  logic              rst;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              ext_sel;
  logic [DATA_W-1:0] ext_data;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              ld_start;
  logic              ld_we;
  logic [DATA_W-1:0] ld_data;
  logic              ld_busy;
  logic              ld_done;
  logic [ADDR_W-1:0] ld_ptr;

  int total;
  int bad;
  int done_count;

  // Behavioural model: program contents, loader progress and read port.
  logic [DATA_W-1:0] m_mem [DEPTH];
  bit                m_loading;
  bit                m_done_pulse;
  int                m_ptr;
  logic [DATA_W-1:0] m_rd_data;
  bit                m_rd_valid;

  typedef struct {
    bit                rd_en;
    logic [ADDR_W-1:0] addr;
    bit                ext_sel;
    logic [DATA_W-1:0] ext_data;
    logic [DATA_W-1:0] exp_data;
    bit                exp_valid;
  } vec_t;

  vec_t vecs [$];

  prog_memory #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .ext_sel (ext_sel),
    .ext_data(ext_data),
    .rd_data (rd_data),
    .rd_valid(rd_valid),
    .ld_start(ld_start),
    .ld_we   (ld_we),
    .ld_data (ld_data),
    .ld_busy (ld_busy),
    .ld_done (ld_done),
    .ld_ptr  (ld_ptr)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected power-up contents of word idx.
  function automatic logic [DATA_W-1:0] bootVal(input int idx);
    logic [DATA_W-1:0] img [8];
    img = '{12'h012, 12'h214, 12'h4C1, 12'h681, 12'h904, 12'hB04, 12'hC07, 12'hFFF};
`ifdef PROG_MEM_BOOTIMG_EN
    return img[idx];
`else
    return (idx >= 0) ? 12'hFFF : img[0];
`endif
  endfunction

  // Compare one value and report it if it differs.
  task automatic checkOutput(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = bootVal(i);
    m_loading    = 0;
    m_done_pulse = 0;
    m_ptr        = 0;
    m_rd_data    = '0;
    m_rd_valid   = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic modelStep();
    if (m_done_pulse) begin
      m_done_pulse = 0;
      m_rd_valid   = 0;
    end else if (m_loading) begin
      m_rd_valid = 0;
      if (ld_start) begin
        m_ptr = 0;
      end else if (ld_we) begin
        m_mem[m_ptr] = ld_data;
        m_ptr = m_ptr + 1;
        if (m_ptr == DEPTH) begin
          m_ptr        = 0;
          m_loading    = 0;
          m_done_pulse = 1;
        end
      end
    end else begin
      if (rd_en) begin
        m_rd_data  = ext_sel ? ext_data : m_mem[rd_addr];
        m_rd_valid = 1;
      end else begin
        m_rd_valid = 0;
      end
      if (ld_start) begin
        m_loading = 1;
        m_ptr     = 0;
      end
    end
  endtask

  task automatic checkAgainstModel();
    checkOutput("rd_data",  rd_data,  m_rd_data);
    checkOutput("rd_valid", rd_valid, m_rd_valid);
    checkOutput("ld_busy",  ld_busy,  m_loading);
    checkOutput("ld_done",  ld_done,  m_done_pulse);
    checkOutput("ld_ptr",   ld_ptr,   m_ptr);
  endtask

  // Drive one cycle of inputs, clock it, and compare against the model.
  task automatic applyStimulus(input bit s_start, input bit s_we, input logic [DATA_W-1:0] s_ldata,
                               input bit s_rden, input logic [ADDR_W-1:0] s_addr,
                               input bit s_ext, input logic [DATA_W-1:0] s_edata);
    ld_start = s_start;
    ld_we    = s_we;
    ld_data  = s_ldata;
    rd_en    = s_rden;
    rd_addr  = s_addr;
    ext_sel  = s_ext;
    ext_data = s_edata;
    @(posedge clk);
    modelStep();
    #1;
    if (ld_done) done_count++;
    checkAgainstModel();
  endtask

  task automatic readWord(input int addr);
    applyStimulus(0, 0, '0, 1, ADDR_W'(addr), 0, '0);
  endtask

  task automatic loadWord(input logic [DATA_W-1:0] d);
    applyStimulus(0, 1, d, 0, '0, 0, '0);
  endtask

  task automatic idleCycle();
    applyStimulus(0, 0, '0, 0, '0, 0, '0);
  endtask

  // Asynchronous reset pulse, checked while held and after release.
  task automatic doReset();
    rst = 1'b1;
    #1;
    modelReset();
    checkAgainstModel();
    @(posedge clk);
    #1;
    rst      = 1'b0;
    ld_start = 0;
    ld_we    = 0;
    rd_en    = 0;
    ext_sel  = 0;
    checkAgainstModel();
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    done_count = 0;
    rst        = 1'b1;
    rd_en      = 0;
    rd_addr    = '0;
    ext_sel    = 0;
    ext_data   = '0;
    ld_start   = 0;
    ld_we      = 0;
    ld_data    = '0;
    modelReset();

    // Directed read vectors: boot image, switch override, then memory again.
    for (int i = 0; i < DEPTH; i++) begin
      vecs.push_back('{1, ADDR_W'(i), 0, 12'h000, bootVal(i), 1});
    end
    vecs.push_back('{1, 3'd3, 1, 12'hABC, 12'hABC, 1});
    vecs.push_back('{1, 3'd3, 0, 12'h000, bootVal(3), 1});
    vecs.push_back('{0, 3'd5, 0, 12'h000, bootVal(3), 0});

    @(posedge clk);
    #1;
    checkOutput("reset_rd_data", rd_data, 0);
    checkOutput("reset_rd_valid", rd_valid, 0);
    checkOutput("reset_ld_busy", ld_busy, 0);
    checkOutput("reset_ld_ptr", ld_ptr, 0);
    rst = 1'b0;

    foreach (vecs[k]) begin
      applyStimulus(0, 0, '0, vecs[k].rd_en, vecs[k].addr, vecs[k].ext_sel, vecs[k].ext_data);
      checkOutput("vec_rd_data", rd_data, vecs[k].exp_data);
      checkOutput("vec_rd_valid", rd_valid, vecs[k].exp_valid);
    end

    // ld_we while idle must not write.
    applyStimulus(0, 1, 12'h555, 0, '0, 0, '0);
    readWord(0);
    checkOutput("idle_we_ignored", rd_data, bootVal(0));

    // Full load of 0x100+i, with a read attempt in the middle.
    done_count = 0;
    applyStimulus(1, 0, '0, 0, '0, 0, '0);
    checkOutput("load_busy", ld_busy, 1);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 4) begin
        applyStimulus(0, 0, '0, 1, 3'd2, 0, '0);
        checkOutput("read_in_load_valid", rd_valid, 0);
      end
      loadWord(12'h100 + 12'(i));
    end
    checkOutput("load_done_now", ld_done, 1);
    checkOutput("load_ptr_wrap", ld_ptr, 0);
    idleCycle();
    checkOutput("load_done_count", done_count, 1);
    for (int i = 0; i < DEPTH; i++) begin
      readWord(i);
      checkOutput("loaded_word", rd_data, 12'h100 + 12'(i));
    end

    // Restart after three words, then a full load; ld_start in DONE ignored.
    done_count = 0;
    applyStimulus(1, 0, '0, 0, '0, 0, '0);
    for (int i = 0; i < 3; i++) loadWord(12'h0A0 + 12'(i));
    applyStimulus(1, 1, 12'h777, 0, '0, 0, '0);
    checkOutput("restart_ptr", ld_ptr, 0);
    for (int i = 0; i < DEPTH; i++) loadWord(12'h200 + 12'(i));
    applyStimulus(1, 0, '0, 0, '0, 0, '0);
    checkOutput("start_in_done_ignored", ld_busy, 0);
    checkOutput("restart_done_count", done_count, 1);
    for (int i = 0; i < DEPTH; i++) begin
      readWord(i);
      checkOutput("reloaded_word", rd_data, 12'h200 + 12'(i));
    end

    // Reset in the middle of a load restores the boot image.
    applyStimulus(1, 0, '0, 0, '0, 0, '0);
    for (int i = 0; i < 4; i++) loadWord(12'h3C0 + 12'(i));
    doReset();
    checkOutput("midload_rst_busy", ld_busy, 0);
    checkOutput("midload_rst_ptr", ld_ptr, 0);
    for (int i = 0; i < 4; i++) begin
      readWord(i);
      checkOutput("boot_after_rst", rd_data, bootVal(i));
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        doReset();
      end else begin
        applyStimulus($urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1,
                      DATA_W'($urandom), $urandom_range(0, 1) == 1,
                      ADDR_W'($urandom), $urandom_range(0, 3) == 0, DATA_W'($urandom));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
